control: RTL and testbench

CONTROL -- requirements
Module: control

---
 rtl/control_if.sv | 25 ++
 rtl/control.sv | 82 ++++++++
 tb/tb_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/control_if.sv
// Host/datapath-facing signal bundle of the divider sequencer.
// The slave side is the sequencer itself; the master side is the host/datapath.
interface control_if;
  logic Req;
  logic nBorrow;
  logic nZ;
  logic Test;
  logic SDI;
  logic Load;
  logic LoadAcc;
  logic ShiftIn;
  logic LoadResult;
  logic Done;
  logic SDO;

  modport slave (
    input  Req, nBorrow, nZ, Test, SDI,
    output Load, LoadAcc, ShiftIn, LoadResult, Done, SDO
  );

  modport master (
    output Req, nBorrow, nZ, Test, SDI,
    input  Load, LoadAcc, ShiftIn, LoadResult, Done, SDO
  );
endinterface

// File: rtl/control.sv
// Restoring-divider sequencer: Req accepted in IDLE -> Load, 8 divide steps, LoadResult, Done (N+11).
// Four-phase handshake; Done is held until Req drops. Test=1 turns state+Count into a scan chain.
module control (
  input  logic     Clock,
  input  logic     Reset,
  control_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD   = 3'b001,
    DIVIDE = 3'b010,
    RESULT = 3'b011,
    DONE   = 3'b100
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] count_q;
  logic [2:0] count_d;

  // Scan order: SDI -> state[0] -> state[1] -> state[2] -> count[0] -> count[1] -> count[2] -> SDO.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= 3'd0;
    end else if (bus.Test) begin
      state_q <= state_t'({state_q[1:0], bus.SDI});
      count_q <= {count_q[1:0], state_q[2]};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = bus.Req ? LOAD : IDLE;
      LOAD:    state_d = bus.nZ ? DIVIDE : RESULT;
      DIVIDE:  state_d = (count_q == 3'd7) ? RESULT : DIVIDE;
      RESULT:  state_d = DONE;
      DONE:    state_d = bus.Req ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case (state_q)
      LOAD:    count_d = 3'd0;
      DIVIDE:  count_d = count_q + 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Only the divide-step strobes look at nBorrow; everything else is pure state decode.
  always_comb begin
    bus.Load       = 1'b0;
    bus.LoadAcc    = 1'b0;
    bus.ShiftIn    = 1'b0;
    bus.LoadResult = 1'b0;
    bus.Done       = 1'b0;
    if (!bus.Test) begin
      case (state_q)
        LOAD:   bus.Load = 1'b1;
        DIVIDE: begin
          bus.LoadAcc = bus.nBorrow;
          bus.ShiftIn = bus.nBorrow;
        end
        RESULT: bus.LoadResult = 1'b1;
        DONE:   bus.Done = 1'b1;
        default: begin
          bus.Load = 1'b0;
        end
      endcase
    end
  end

  assign bus.SDO = count_q[2];

endmodule

// File: tb/tb_control.sv
// Randomized check of the divider sequencer against a transaction-level expected-output schedule.
module tb_control;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  control_if bus ();

  control dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.Load, bus.LoadAcc, bus.ShiftIn, bus.LoadResult, bus.Done};
  endfunction

  // Inputs are set just before the call; outputs for this cycle are sampled on the falling edge.
  task automatic cyc_check(input string tag, input logic [4:0] exp);
    @(negedge clk);
    check(tag, int'(outs()), int'(exp));
    @(posedge clk);
    #1;
  endtask

  // Expected schedule of one request: Load, 8 steps (skipped on zero divisor), LoadResult, Done.
  task automatic run_txn(input bit zero, input int hold, input logic [7:0] pat, input bit use_pat);
    logic b;
    bus.Req = 1'b1; bus.nZ = 1'($urandom); bus.nBorrow = 1'($urandom);
    cyc_check("idle_accept", 5'b00000);
    bus.Req = 1'($urandom); bus.nZ = !zero;
    cyc_check("load", 5'b10000);
    if (!zero) begin
      for (int i = 0; i < 8; i++) begin
        b = use_pat ? pat[7-i] : 1'($urandom);
        bus.nBorrow = b; bus.nZ = 1'($urandom); bus.Req = 1'($urandom);
        cyc_check("divide", {1'b0, b, b, 2'b00});
      end
    end
    bus.Req = 1'($urandom); bus.nBorrow = 1'($urandom);
    cyc_check("result", 5'b00010);
    for (int h = 0; h < hold; h++) begin
      bus.Req = 1'b1;
      cyc_check("done_hold", 5'b00001);
    end
    bus.Req = 1'b0;
    cyc_check("done_drop", 5'b00001);
    bus.Req = 1'b0;
    cyc_check("back_idle", 5'b00000);
  endtask

  logic [5:0] scan_pat;

  initial begin
    checks = 0; errors = 0;
    bus.Req = 1'b1; bus.nBorrow = 1'b1; bus.nZ = 1'b1; bus.Test = 1'b1; bus.SDI = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset has priority over Test and Req.
    @(negedge clk);
    check("rst_sdo", int'(bus.SDO), 0);
    check("rst_outs_test", int'(outs()), 0);
    bus.Test = 1'b0; bus.Req = 1'b0;
    @(negedge clk);
    check("rst_outs", int'(outs()), 0);
    check("rst_sdo2", int'(bus.SDO), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.Req = 1'b0;
    cyc_check("idle_quiet", 5'b00000);

    run_txn(1'b0, 3, 8'hFF, 1'b1);
    run_txn(1'b0, 2, 8'b11001011, 1'b1);
    run_txn(1'b1, 1, 8'h00, 1'b0);
    run_txn(1'b0, 5, 8'h00, 1'b0);

    for (int t = 0; t < 30; t++)
      run_txn(($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), 8'h00, 1'b0);

    // Reset in the 4th divide cycle aborts with no LoadResult/Done.
    bus.Req = 1'b1; bus.nZ = 1'b1;
    cyc_check("ab_idle", 5'b00000);
    cyc_check("ab_load", 5'b10000);
    for (int i = 0; i < 3; i++) begin
      bus.nBorrow = 1'b1;
      cyc_check("ab_div", 5'b01100);
    end
    rst = 1'b1; bus.nBorrow = 1'b1;
    cyc_check("ab_div4", 5'b01100);
    bus.Req = 1'b0;
    cyc_check("ab_after_rst", 5'b00000);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc_check("ab_quiet", 5'b00000);

    // Scan chain: bits emerge on SDO six edges after entering, functional outputs forced low.
    scan_pat = 6'b101100;
    bus.Test = 1'b1; bus.nBorrow = 1'b1; bus.Req = 1'b1; bus.nZ = 1'b1;
    for (int k = 0; k < 12; k++) begin
      bus.SDI = (k < 6) ? scan_pat[5-k] : 1'b0;
      @(negedge clk);
      check("scan_outs", int'(outs()), 0);
      if (k >= 6) check("scan_sdo", int'(bus.SDO), int'(scan_pat[5-(k-6)]));
      @(posedge clk); #1;
    end

    // Load an unused state code (111) through the chain, then leave scan mode.
    for (int k = 0; k < 3; k++) begin
      bus.SDI = 1'b1;
      @(posedge clk); #1;
    end
    bus.Test = 1'b0; bus.Req = 1'b0; bus.SDI = 1'b0;
    cyc_check("unused_state", 5'b00000);
    run_txn(1'b0, 1, 8'h00, 1'b0);
    run_txn(1'b1, 0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
